ymc_ctrl: RTL and testbench

- Multi-cycle control sequencer for the 32-bit MIPS datapath (yIF/yID/yEX/yDM/yWB/yPC).
- Consumes the fetched instruction word and the ALU zero flag. Decodes them into datapath control levels and one-cycle write/PC-update strobes.
- Replaces bench-driven control: boots the PC to the entry point, steps each instruction through FETCH/DECODE/EXEC/MEM/WB, and halts after a programmed instruction count.

---
 rtl/ymc_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_ymc_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ymc_ctrl.sv
// ---------------------------------------------------------------------------
// ymc_ctrl -- multi-cycle control sequencer for the 32-bit MIPS datapath
// (yIF / yID / yEX / yDM / yWB / yPC).
//
// Boots the PC to ENTRY, then steps every instruction through
// FETCH / DECODE / EXEC / MEM / WB. The datapath control levels are decoded
// once in DECODE and held until the end of the instruction. The write and PC
// strobes are single-cycle pulses. After MAX_INSTR retirements the sequencer
// parks in HALT (MAX_INSTR = 0 runs forever).
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   ins        in  32   current instruction word from yIF
//   zero       in   1   ALU zero flag from yEX (consumed by yPC, see below)
//   RegDst     out  1   1 = rd (R-type), 0 = rt
//   RegWrite   out  1   register-file write strobe (WB cycle only)
//   ALUSrc     out  1   1 = immediate operand
//   MemRead    out  1   data-memory read enable
//   MemWrite   out  1   data-memory write strobe (MEM cycle only)
//   Mem2Reg    out  1   1 = write back memOut
//   branch     out  1   beq select to yPC
//   jump       out  1   j select to yPC
//   op         out  3   ALU op
//   INT        out  1   boot select to yPC
//   entryPoint out 32   constant ENTRY
//   pc_en      out  1   one-cycle PC load strobe
//   retired    out 16   count of completed instructions
//   illegal    out  1   sticky: unsupported opcode/funct seen
//   halted     out  1   1 in HALT
// ---------------------------------------------------------------------------
module ymc_ctrl #(
    parameter logic [31:0] ENTRY     = 32'd128,
    parameter logic [15:0] MAX_INSTR = 16'd43
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    input  logic        zero,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Mem2Reg,
    output logic        branch,
    output logic        jump,
    output logic [2:0]  op,
    output logic        INT,
    output logic [31:0] entryPoint,
    output logic        pc_en,
    output logic [15:0] retired,
    output logic        illegal,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    // Instruction class chooses the sequence length and which strobe fires.
    typedef enum logic [2:0] {
        C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_ILL
    } iclass_t;

    // Datapath control levels, held from DECODE to the end of the instruction.
    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memread;
        logic       mem2reg;
        logic       branch;
        logic       jump;
        logic [2:0] op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = 9'b000000_010;

    state_t      state_q, state_d;
    iclass_t     class_q, class_d;
    ctrl_t       ctrl_q,  ctrl_d;
    logic        illegal_q, illegal_d;
    logic [15:0] retired_q, retired_d;
    // Low only in the first cycle after reset. Keeps the BOOT strobes quiet
    // while rst_n is asserted, so BOOT shows up in the cycle after release.
    logic        armed_q, armed_d;

    iclass_t     dec_class;
    ctrl_t       dec_ctrl;
    logic        retire;
    logic [15:0] retired_inc;

    // zero is sampled by yPC at the pc_en edge. beq takes three cycles
    // whether or not it is taken, so the sequencer itself never needs zero.
    // Only the opcode and funct fields of ins are decoded here.
    logic unused_inputs;
    assign unused_inputs = ^{zero, ins[25:6]};

    // ------------------------------------------------------------------
    // Instruction decode (only consumed in DECODE)
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        dec_class = C_ILL;
        dec_ctrl  = CTRL_NOP;
        unique case (ins[31:26])
            6'h00: begin
                dec_ctrl.regdst = 1'b1;
                dec_class       = C_R;
                unique case (ins[5:0])
                    6'h24:   dec_ctrl.op = 3'b000;
                    6'h25:   dec_ctrl.op = 3'b001;
                    6'h20:   dec_ctrl.op = 3'b010;
                    6'h22:   dec_ctrl.op = 3'b110;
                    6'h2a:   dec_ctrl.op = 3'b111;
                    default: begin
                        dec_class = C_ILL;
                        dec_ctrl  = CTRL_NOP;
                    end
                endcase
            end
            6'h08: begin
                dec_class       = C_ADDI;
                dec_ctrl.alusrc = 1'b1;
            end
            6'h23: begin
                dec_class        = C_LW;
                dec_ctrl.alusrc  = 1'b1;
                dec_ctrl.memread = 1'b1;
                dec_ctrl.mem2reg = 1'b1;
            end
            6'h2b: begin
                dec_class       = C_SW;
                dec_ctrl.alusrc = 1'b1;
            end
            6'h04: begin
                dec_class       = C_BEQ;
                dec_ctrl.branch = 1'b1;
                dec_ctrl.op     = 3'b110;
            end
            6'h02: begin
                dec_class       = C_J;
                dec_ctrl.jump   = 1'b1;
                dec_ctrl.alusrc = 1'b1;
            end
            default: begin
                dec_class = C_ILL;
                dec_ctrl  = CTRL_NOP;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer: next state and strobes
    // ------------------------------------------------------------------
    assign retired_inc = retired_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        armed_d   = 1'b1;
        retire    = 1'b0;
        INT       = 1'b0;
        pc_en     = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            S_BOOT: begin
                if (armed_q) begin
                    INT     = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ctrl_d  = dec_ctrl;
                class_d = dec_class;
                if (dec_class == C_ILL) illegal_d = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                unique case (class_q)
                    C_LW, C_SW:  state_d = S_MEM;
                    C_R, C_ADDI: state_d = S_WB;
                    default:     retire  = 1'b1;   // beq, j, illegal
                endcase
            end
            S_MEM: begin
                if (class_q == C_SW) begin
                    MemWrite = 1'b1;
                    retire   = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_HALT:  halted  = 1'b1;
            default: state_d = S_BOOT;
        endcase

        // Last cycle of an instruction: pulse the PC, drop the levels so the
        // next FETCH starts clean, and count the retirement.
        if (retire) begin
            pc_en  = 1'b1;
            ctrl_d = CTRL_NOP;
            if (retired_q != 16'hFFFF) retired_d = retired_inc;
            if (MAX_INSTR != 16'd0 && retired_inc == MAX_INSTR) state_d = S_HALT;
            else                                                 state_d = S_FETCH;
        end
    end

    // NOTE: sequential state is assigned with non-blocking (<=) only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            class_q   <= C_ILL;
            ctrl_q    <= CTRL_NOP;
            illegal_q <= 1'b0;
            retired_q <= 16'd0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            armed_q   <= armed_d;
        end
    end

    assign RegDst     = ctrl_q.regdst;
    assign ALUSrc     = ctrl_q.alusrc;
    assign MemRead    = ctrl_q.memread;
    assign Mem2Reg    = ctrl_q.mem2reg;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign op         = ctrl_q.op;
    assign entryPoint = ENTRY;
    assign retired    = retired_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_ymc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ymc_ctrl -- directed bench for ymc_ctrl.
// dut   : default parameters (ENTRY = 128, MAX_INSTR = 43).
// dut_h : MAX_INSTR = 3, used for the halt scenario.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ymc_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, zero;
    logic [31:0] ins;
    logic        RegDst, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg;
    logic        branch, jump, INT, pc_en, illegal, halted;
    logic [2:0]  op;
    logic [31:0] entryPoint;
    logic [15:0] retired;

    logic        h_rst_n;
    logic [31:0] h_ins;
    logic        h_RegDst, h_RegWrite, h_ALUSrc, h_MemRead, h_MemWrite, h_Mem2Reg;
    logic        h_branch, h_jump, h_INT, h_pc_en, h_illegal, h_halted;
    logic [2:0]  h_op;
    logic [31:0] h_entryPoint;
    logic [15:0] h_retired;

    int vectors     = 0;
    int miscompares = 0;
    int exp_ret     = 0;

    localparam logic [31:0] I_ADD = 32'h012A4020;
    localparam logic [31:0] I_LW  = 32'h8D090004;
    localparam logic [31:0] I_SW  = 32'hAD090004;
    localparam logic [31:0] I_BEQ = 32'h1109FFFE;
    localparam logic [31:0] I_J   = 32'h08000020;
    localparam logic [31:0] I_BAD = 32'hFC000000;

    ymc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .zero(zero),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg),
        .branch(branch), .jump(jump), .op(op), .INT(INT),
        .entryPoint(entryPoint), .pc_en(pc_en), .retired(retired),
        .illegal(illegal), .halted(halted)
    );

    ymc_ctrl #(.ENTRY(32'd128), .MAX_INSTR(16'd3)) dut_h (
        .clk(clk), .rst_n(h_rst_n), .ins(h_ins), .zero(zero),
        .RegDst(h_RegDst), .RegWrite(h_RegWrite), .ALUSrc(h_ALUSrc),
        .MemRead(h_MemRead), .MemWrite(h_MemWrite), .Mem2Reg(h_Mem2Reg),
        .branch(h_branch), .jump(h_jump), .op(h_op), .INT(h_INT),
        .entryPoint(h_entryPoint), .pc_en(h_pc_en), .retired(h_retired),
        .illegal(h_illegal), .halted(h_halted)
    );

    // Runs one instruction on dut, starting at the falling edge of its FETCH
    // cycle (cycle 1), and ends at the falling edge of the following cycle.
    // lv packs {RegDst,ALUSrc,MemRead,Mem2Reg,branch,jump,op} seen in EXEC.
    task automatic observe(input logic [31:0] iw, input logic z,
                           output int n_cyc, output int rw_cnt, output int rw_cyc,
                           output int mw_cnt, output logic [8:0] lv,
                           output logic fetch_clean, output logic [15:0] ret_after);
        n_cyc = 0; rw_cnt = 0; rw_cyc = 0; mw_cnt = 0; lv = '0;
        fetch_clean = (RegWrite === 1'b0 && MemWrite === 1'b0 && pc_en === 1'b0 &&
                       INT === 1'b0 && RegDst === 1'b0 && ALUSrc === 1'b0 &&
                       MemRead === 1'b0 && Mem2Reg === 1'b0 && branch === 1'b0 &&
                       jump === 1'b0 && op === 3'b010 && halted === 1'b0);
        ins  = iw;
        zero = z;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (c == 3) lv = {RegDst, ALUSrc, MemRead, Mem2Reg, branch, jump, op};
            if (RegWrite === 1'b1) begin rw_cnt++; rw_cyc = c; end
            if (MemWrite === 1'b1) mw_cnt++;
            if (pc_en === 1'b1) begin n_cyc = c; break; end
        end
        @(negedge clk);
        ret_after = retired;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ins = I_LW; zero = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({INT, pc_en, RegWrite, MemWrite, RegDst, ALUSrc, MemRead, Mem2Reg,
             branch, jump, illegal, halted} !== 12'd0 || op !== 3'b010 || retired !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: ctl=%b op=%b retired=%0d, want all 0, op=010, retired=0",
                     {INT, pc_en, RegWrite, MemWrite, RegDst, ALUSrc, MemRead, Mem2Reg,
                      branch, jump, illegal, halted}, op, retired);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (INT !== 1'b1 || pc_en !== 1'b1 || entryPoint !== 32'd128) begin
            miscompares++;
            $display("FAIL boot_cycle: INT=%b pc_en=%b entryPoint=%0d, want 1 1 128",
                     INT, pc_en, entryPoint);
        end
        @(negedge clk);
        vectors++;
        if (INT !== 1'b0 || pc_en !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0 ||
            retired !== 16'd0) begin
            miscompares++;
            $display("FAIL fetch_after_boot: INT=%b pc_en=%b RegWrite=%b MemWrite=%b retired=%0d, want 0 0 0 0 0",
                     INT, pc_en, RegWrite, MemWrite, retired);
        end
    endtask

    task automatic test_rtype();
        int n, rwc, rwy, mwc; logic [8:0] lv; logic fc; logic [15:0] ret;
        observe(I_ADD, 1'b0, n, rwc, rwy, mwc, lv, fc, ret);
        exp_ret++;
        vectors++;
        if (n != 4 || !fc) begin
            miscompares++;
            $display("FAIL add_cycles: cycles=%0d fetch_clean=%b, want 4 1", n, fc);
        end
        vectors++;
        if (rwc != 1 || rwy != 4 || mwc != 0) begin
            miscompares++;
            $display("FAIL add_strobes: rw_cnt=%0d rw_cyc=%0d mw_cnt=%0d, want 1 4 0", rwc, rwy, mwc);
        end
        vectors++;
        if (lv !== 9'b100000010) begin
            miscompares++;
            $display("FAIL add_levels: got %b want 100000010", lv);
        end
        vectors++;
        if (ret !== 16'(exp_ret) || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL add_retired: retired=%0d illegal=%b, want %0d 0", ret, illegal, exp_ret);
        end
    endtask

    task automatic test_load_store();
        logic [31:0] iw [2]  = '{I_LW, I_SW};
        int          ecyc[2] = '{5, 4};
        int          erwc[2] = '{1, 0};
        int          erwy[2] = '{5, 0};
        int          emwc[2] = '{0, 1};
        logic [8:0]  elv [2] = '{9'b011100010, 9'b010000010};
        int n, rwc, rwy, mwc; logic [8:0] lv; logic fc; logic [15:0] ret;
        for (int i = 0; i < 2; i++) begin
            observe(iw[i], 1'b0, n, rwc, rwy, mwc, lv, fc, ret);
            exp_ret++;
            vectors++;
            if (n != ecyc[i] || !fc) begin
                miscompares++;
                $display("FAIL ldst%0d_cycles: cycles=%0d fetch_clean=%b, want %0d 1", i, n, fc, ecyc[i]);
            end
            vectors++;
            if (rwc != erwc[i] || rwy != erwy[i] || mwc != emwc[i]) begin
                miscompares++;
                $display("FAIL ldst%0d_strobes: rw_cnt=%0d rw_cyc=%0d mw_cnt=%0d, want %0d %0d %0d",
                         i, rwc, rwy, mwc, erwc[i], erwy[i], emwc[i]);
            end
            vectors++;
            if (lv !== elv[i]) begin
                miscompares++;
                $display("FAIL ldst%0d_levels: got %b want %b", i, lv, elv[i]);
            end
            vectors++;
            if (ret !== 16'(exp_ret)) begin
                miscompares++;
                $display("FAIL ldst%0d_retired: got %0d want %0d", i, ret, exp_ret);
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] iw [2] = '{I_BEQ, I_J};
        logic [8:0]  elv[2] = '{9'b000010110, 9'b010001010};
        int n, rwc, rwy, mwc; logic [8:0] lv; logic fc; logic [15:0] ret;
        for (int i = 0; i < 2; i++) begin
            observe(iw[i], 1'b1, n, rwc, rwy, mwc, lv, fc, ret);
            exp_ret++;
            vectors++;
            if (n != 3 || !fc) begin
                miscompares++;
                $display("FAIL brj%0d_cycles: cycles=%0d fetch_clean=%b, want 3 1", i, n, fc);
            end
            vectors++;
            if (rwc != 0 || mwc != 0) begin
                miscompares++;
                $display("FAIL brj%0d_strobes: rw_cnt=%0d mw_cnt=%0d, want 0 0", i, rwc, mwc);
            end
            vectors++;
            if (lv !== elv[i]) begin
                miscompares++;
                $display("FAIL brj%0d_levels: got %b want %b", i, lv, elv[i]);
            end
            vectors++;
            if (ret !== 16'(exp_ret)) begin
                miscompares++;
                $display("FAIL brj%0d_retired: got %0d want %0d", i, ret, exp_ret);
            end
        end
    endtask

    task automatic test_illegal();
        int n, rwc, rwy, mwc; logic [8:0] lv; logic fc; logic [15:0] ret;
        observe(I_BAD, 1'b0, n, rwc, rwy, mwc, lv, fc, ret);
        exp_ret++;
        vectors++;
        if (n != 3 || rwc != 0 || mwc != 0 || lv !== 9'b000000010) begin
            miscompares++;
            $display("FAIL illegal_seq: cycles=%0d rw=%0d mw=%0d levels=%b, want 3 0 0 000000010",
                     n, rwc, mwc, lv);
        end
        vectors++;
        if (illegal !== 1'b1 || ret !== 16'(exp_ret)) begin
            miscompares++;
            $display("FAIL illegal_flag: illegal=%b retired=%0d, want 1 %0d", illegal, ret, exp_ret);
        end
        observe(I_ADD, 1'b0, n, rwc, rwy, mwc, lv, fc, ret);
        exp_ret++;
        vectors++;
        if (n != 4 || rwc != 1 || rwy != 4 || lv !== 9'b100000010 || !fc) begin
            miscompares++;
            $display("FAIL add_after_illegal: cycles=%0d rw=%0d@%0d levels=%b clean=%b, want 4 1@4 100000010 1",
                     n, rwc, rwy, lv, fc);
        end
        vectors++;
        if (illegal !== 1'b1 || ret !== 16'(exp_ret)) begin
            miscompares++;
            $display("FAIL illegal_sticky: illegal=%b retired=%0d, want 1 %0d", illegal, ret, exp_ret);
        end
    endtask

    task automatic test_reset_mid();
        logic got_wb = 1'b0;
        int   bad    = 0;
        ins = I_LW;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (RegWrite === 1'b1) begin got_wb = 1'b1; break; end
        end
        vectors++;
        if (!got_wb) begin
            miscompares++;
            $display("FAIL lw_reach_wb: RegWrite never seen within 8 cycles, want 1");
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({RegWrite, pc_en, MemRead, Mem2Reg, ALUSrc, illegal, halted} !== 7'd0 ||
            op !== 3'b010 || retired !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid_wb: ctl=%b op=%b retired=%0d, want 0000000 010 0",
                     {RegWrite, pc_en, MemRead, Mem2Reg, ALUSrc, illegal, halted}, op, retired);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        if (RegWrite !== 1'b0 || MemWrite !== 1'b0 || pc_en !== 1'b0) bad++;
        @(negedge clk);
        vectors++;
        if (INT !== 1'b1 || pc_en !== 1'b1 || RegWrite !== 1'b0 || MemWrite !== 1'b0 || bad != 0) begin
            miscompares++;
            $display("FAIL restart_boot: INT=%b pc_en=%b RegWrite=%b MemWrite=%b early=%0d, want 1 1 0 0 0",
                     INT, pc_en, RegWrite, MemWrite, bad);
        end
        @(negedge clk);
        vectors++;
        if (INT !== 1'b0 || pc_en !== 1'b0 || RegWrite !== 1'b0 || retired !== 16'd0) begin
            miscompares++;
            $display("FAIL restart_fetch: INT=%b pc_en=%b RegWrite=%b retired=%0d, want 0 0 0 0",
                     INT, pc_en, RegWrite, retired);
        end
    endtask

    task automatic test_halt();
        int pc_cnt = 0, ret_cnt = 0, rw_cnt = 0, third_cyc = 0, halt_cyc = 0, late = 0;
        h_ins = I_ADD;
        @(negedge clk);
        h_rst_n = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (halt_cyc != 0 && (h_pc_en || h_RegWrite || h_MemWrite || h_INT ||
                                  h_RegDst || h_ALUSrc || h_MemRead || h_Mem2Reg ||
                                  h_branch || h_jump || !h_halted)) late++;
            if (h_pc_en === 1'b1) begin
                pc_cnt++;
                if (h_INT !== 1'b1) begin
                    ret_cnt++;
                    if (ret_cnt == 3) third_cyc = cyc;
                end
            end
            if (h_RegWrite === 1'b1) rw_cnt++;
            if (h_halted === 1'b1 && halt_cyc == 0) halt_cyc = cyc;
        end
        vectors++;
        if (pc_cnt != 4 || rw_cnt != 3 || third_cyc != 13) begin
            miscompares++;
            $display("FAIL halt_strobes: pc_en=%0d RegWrite=%0d third_retire@%0d, want 4 3 13",
                     pc_cnt, rw_cnt, third_cyc);
        end
        vectors++;
        if (halt_cyc != 14 || late != 0) begin
            miscompares++;
            $display("FAIL halt_entry: halted@%0d activity_after=%0d, want 14 0", halt_cyc, late);
        end
        vectors++;
        if (h_halted !== 1'b1 || h_retired !== 16'd3) begin
            miscompares++;
            $display("FAIL halt_state: halted=%b retired=%0d, want 1 3", h_halted, h_retired);
        end
    endtask

    initial begin
        h_rst_n = 1'b0;
        h_ins   = 32'd0;
        test_reset();
        test_rtype();
        test_load_store();
        test_branch_jump();
        test_illegal();
        test_reset_mid();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
